chip_piso_seq: RTL

- Parametrised parallel-in/serial-out shift register for the bench chip library.
- Next-generation replacement for the fixed 8-bit load/shift chip model.
- Adds generic width, selectable MSB/LSB-first order, clock inhibit and a built-in frame sequencer: a START request loads the word, shifts out exactly WIDTH bits, then pulses DONE.
- Bench harnesses use it to drive serial links into the DUT without hand-toggling SH_LDn.

---
 rtl/chip_piso_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/chip_piso_seq.sv
// chip_piso_seq
// Parallel-in/serial-out shift register with a built-in frame sequencer.
// A START request loads the parallel word. The block then shifts out exactly
// WIDTH bits, MSB-first or LSB-first, and pulses DONE for one cycle.
//
// Ports:
//   CLK        clock; all state changes on the rising edge
//   RSTn       synchronous active-low reset
//   CLK_INH    clock inhibit; freezes load, shift and count while high
//   START      frame request, honoured only in IDLE or DONE
//   LSB_FIRST  bit order, latched at load (0 = MSB first)
//   D          parallel word captured on the accept edge
//   SER        serial fill bit entering the vacated end on each shift
//   Q          serial output, the current frame bit
//   PAR_Q      direct view of the shift register
//   BUSY       high while in SHIFT
//   DONE       one-cycle pulse after the last bit of a frame
//   BIT_CNT    index of the bit currently on Q
module chip_piso_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             CLK_INH,
  input  logic             START,
  input  logic             LSB_FIRST,
  input  logic [WIDTH-1:0] D,
  input  logic             SER,
  output logic             Q,
  output logic [WIDTH-1:0] PAR_Q,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] BIT_CNT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh_reg;
  logic             order_lsb;

  // The serial bit is whichever end of the register leaves next, so Q is
  // simply a tap selected by the order latched at load time.
  assign Q     = order_lsb ? sh_reg[0] : sh_reg[WIDTH-1];
  assign PAR_Q = sh_reg;

  // Frame sequencer. BUSY and DONE are registered alongside the state so they
  // change on the same edge as the state and can never overlap.
  // DONE always falls back to IDLE after one cycle unless a new frame is
  // accepted, even under inhibit, so the pulse stays exactly one cycle long.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state     <= S_IDLE;
      sh_reg    <= '0;
      order_lsb <= 1'b0;
      BIT_CNT   <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (START && !CLK_INH) begin
            sh_reg    <= D;
            order_lsb <= LSB_FIRST;
            BIT_CNT   <= '0;
            state     <= S_SHIFT;
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
          end else if (state == S_DONE) begin
            state <= S_IDLE;
            DONE  <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (!CLK_INH) begin
            if (order_lsb) begin
              sh_reg <= {SER, sh_reg[WIDTH-1:1]};
            end else begin
              sh_reg <= {sh_reg[WIDTH-2:0], SER};
            end
            if (BIT_CNT == LAST_BIT) begin
              BIT_CNT <= '0;
              state   <= S_DONE;
              BUSY    <= 1'b0;
              DONE    <= 1'b1;
            end else begin
              BIT_CNT <= BIT_CNT + CNT_W'(1);
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          BIT_CNT <= '0;
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
        end
      endcase
    end
  end

endmodule
